// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The master side is the sequencer; the slave side is the datapath.
interface pipeline_hazard_ctrl_if;
  logic [4:0] IF_ID_rs1;
  logic [4:0] IF_ID_rs2;
  logic [4:0] ID_EX_rd;
  logic       ID_EX_MemRead;
  logic       EX_MEM_Branch;
  logic       EX_MEM_zero;
  logic       EX_MEM_MemRead;
  logic       EX_MEM_MemWrite;
  logic       mem_ready;
  logic       mem_req;
  logic       pc_write;
  logic       pc_src;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       ID_EX_bubble;
  logic       ID_EX_hold;
  logic       ID_EX_flush;
  logic       EX_MEM_hold;
  logic       EX_MEM_flush;
  logic       mem_err;
  logic [1:0] ctrl_state;

  modport master (
    input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_MemRead,
    input  EX_MEM_Branch, EX_MEM_zero, EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready,
    output mem_req, pc_write, pc_src, IF_ID_write, IF_ID_flush,
    output ID_EX_bubble, ID_EX_hold, ID_EX_flush, EX_MEM_hold, EX_MEM_flush,
    output mem_err, ctrl_state
  );

  modport slave (
    output IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_MemRead,
    output EX_MEM_Branch, EX_MEM_zero, EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready,
    input  mem_req, pc_write, pc_src, IF_ID_write, IF_ID_flush,
    input  ID_EX_bubble, ID_EX_hold, ID_EX_flush, EX_MEM_hold, EX_MEM_flush,
    input  mem_err, ctrl_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, memory wait, timeout.
// Defining HAZARD_PERF_CNT_EN adds saturating stall/flush/mem-wait performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_count
  , output logic [CNT_W-1:0] mem_wait_cycles
`endif
);
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic mem_access, taken, load_use, free_c;
  logic mem_req_c, pc_write_c, pc_src_c, if_id_write_c, if_id_flush_c;
  logic id_ex_bubble_c, id_ex_hold_c, id_ex_flush_c, ex_mem_hold_c, ex_mem_flush_c;

  assign mem_access = hz.EX_MEM_MemRead | hz.EX_MEM_MemWrite;
  assign taken      = hz.EX_MEM_Branch & hz.EX_MEM_zero;
  assign load_use   = hz.ID_EX_MemRead && (hz.ID_EX_rd != 5'd0) &&
                      ((hz.ID_EX_rd == hz.IF_ID_rs1) || (hz.ID_EX_rd == hz.IF_ID_rs2));

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next-state and zero-latency control decode
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    err_d          = err_q;
    free_c         = 1'b0;
    mem_req_c      = 1'b0;
    pc_write_c     = 1'b0;
    pc_src_c       = 1'b0;
    if_id_write_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    id_ex_hold_c   = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_hold_c  = 1'b0;
    ex_mem_flush_c = 1'b0;

    if (!reset) begin
      case (state_q)
        RUN: begin
          if (mem_access) begin
            mem_req_c = 1'b1;
            if (hz.mem_ready) begin
              free_c = 1'b1;
            end else begin
              id_ex_hold_c  = 1'b1;
              ex_mem_hold_c = 1'b1;
              state_d       = MEM_WAIT;
              wait_d        = WAIT_W'(1);
            end
          end else begin
            free_c = 1'b1;
          end
        end
        MEM_WAIT: begin
          mem_req_c = 1'b1;
          if (hz.mem_ready) begin
            free_c  = 1'b1;
            state_d = RUN;
            wait_d  = '0;
          end else begin
            id_ex_hold_c  = 1'b1;
            ex_mem_hold_c = 1'b1;
            if (wait_q == TIMEOUT) begin
              state_d = ERROR;
              err_d   = 1'b1;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
        end
        ERROR: begin
          // Whole pipeline stays frozen until reset
          id_ex_hold_c  = 1'b1;
          ex_mem_hold_c = 1'b1;
        end
        default: begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      endcase

      // Pipeline advances; a taken branch flush overrides a load-use bubble
      if (free_c) begin
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if (taken) begin
          pc_src_c       = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_flush_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
        end else if (load_use) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
        end
      end
    end
  end

  assign hz.mem_req      = mem_req_c;
  assign hz.pc_write     = pc_write_c;
  assign hz.pc_src       = pc_src_c;
  assign hz.IF_ID_write  = if_id_write_c;
  assign hz.IF_ID_flush  = if_id_flush_c;
  assign hz.ID_EX_bubble = id_ex_bubble_c;
  assign hz.ID_EX_hold   = id_ex_hold_c;
  assign hz.ID_EX_flush  = id_ex_flush_c;
  assign hz.EX_MEM_hold  = ex_mem_hold_c;
  assign hz.EX_MEM_flush = ex_mem_flush_c;
  assign hz.mem_err      = ~reset & err_q;
  assign hz.ctrl_state   = reset ? 2'd0 : 2'(state_q);

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters, frozen once the controller is in ERROR
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= '0;
      flush_count     <= '0;
      mem_wait_cycles <= '0;
    end else if (state_q != ERROR) begin
      if (!pc_write_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_src_c && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
      if ((state_q == MEM_WAIT) && (mem_wait_cycles != '1))
        mem_wait_cycles <= mem_wait_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl with MEM_TIMEOUT=4.
// Also checks the HAZARD_PERF_CNT_EN counters when that macro is defined.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, mem_wait_cycles;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles    (stall_cycles)
    , .flush_count     (flush_count)
    , .mem_wait_cycles (mem_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  // {mem_req, pc_write, pc_src, IF_ID_write, IF_ID_flush, ID_EX_bubble,
  //  ID_EX_hold, ID_EX_flush, EX_MEM_hold, EX_MEM_flush, mem_err, ctrl_state[1:0]}
  logic [12:0] ctl;
  assign ctl = {hz.mem_req, hz.pc_write, hz.pc_src, hz.IF_ID_write, hz.IF_ID_flush,
                hz.ID_EX_bubble, hz.ID_EX_hold, hz.ID_EX_flush, hz.EX_MEM_hold,
                hz.EX_MEM_flush, hz.mem_err, hz.ctrl_state};

  localparam logic [12:0] ALL_ZERO    = 13'b0_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [12:0] RUN_DEF     = 13'b0_1_0_1_0_0_0_0_0_0_0_00;
  localparam logic [12:0] LOAD_USE    = 13'b0_0_0_0_0_1_0_0_0_0_0_00;
  localparam logic [12:0] BRANCH      = 13'b0_1_1_1_1_0_0_1_0_1_0_00;
  localparam logic [12:0] MEM_OK_RUN  = 13'b1_1_0_1_0_0_0_0_0_0_0_00;
  localparam logic [12:0] FREEZE_RUN  = 13'b1_0_0_0_0_0_1_0_1_0_0_00;
  localparam logic [12:0] FREEZE_WAIT = 13'b1_0_0_0_0_0_1_0_1_0_0_01;
  localparam logic [12:0] FREE_WAIT   = 13'b1_1_0_1_0_0_0_0_0_0_0_01;
  localparam logic [12:0] BR_WAIT     = 13'b1_1_1_1_1_0_0_1_0_1_0_01;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic idmr, input logic br, input logic zero,
                       input logic mr, input logic mw, input logic rdy);
    hz.IF_ID_rs1       = rs1;
    hz.IF_ID_rs2       = rs2;
    hz.ID_EX_rd        = rd;
    hz.ID_EX_MemRead   = idmr;
    hz.EX_MEM_Branch   = br;
    hz.EX_MEM_zero     = zero;
    hz.EX_MEM_MemRead  = mr;
    hz.EX_MEM_MemWrite = mw;
    hz.mem_ready       = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset forces every output low even with hazards present
    reset = 1'b1;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_outputs", 32'(ctl), 32'(ALL_ZERO));
    tick();
    chk("reset_outputs_held", 32'(ctl), 32'(ALL_ZERO));
    tick();
    reset = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("run_default", 32'(ctl), 32'(RUN_DEF));
    tick();

    // Load-use on rs2
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_use_rs2", 32'(ctl), 32'(LOAD_USE));
    tick();
    drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_use_one_cycle", 32'(ctl), 32'(RUN_DEF));
    tick();

    // rd = x0 never stalls
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_use_x0", 32'(ctl), 32'(RUN_DEF));
    tick();

    // Load-use on rs1
    drive(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_use_rs1", 32'(ctl), 32'(LOAD_USE));
    tick();

    // Taken branch then untaken branch
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("branch_taken", 32'(ctl), 32'(BRANCH));
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("branch_not_taken", 32'(ctl), 32'(RUN_DEF));
    tick();

    // Branch flush wins over load-use
    drive(5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("branch_over_load_use", 32'(ctl), 32'(BRANCH));
    tick();

    // Memory access completing in the same cycle
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mem_ready_same_cycle", 32'(ctl), 32'(MEM_OK_RUN));
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mem_no_wait_state", 32'(ctl), 32'(RUN_DEF));

    // Memory wait: ready low three cycles, then high
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mem_freeze_run", 32'(ctl), 32'(FREEZE_RUN));
    tick();
    chk("mem_wait_1", 32'(ctl), 32'(FREEZE_WAIT));
    tick();
    chk("mem_wait_2", 32'(ctl), 32'(FREEZE_WAIT));
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mem_release", 32'(ctl), 32'(FREE_WAIT));
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mem_back_to_run", 32'(ctl), 32'(RUN_DEF));
    tick();

    // Store with taken branch: stall first, branch applied on completion
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mem_over_branch", 32'(ctl), 32'(FREEZE_RUN));
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("deferred_branch", 32'(ctl), 32'(BR_WAIT));
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_deferred_branch", 32'(ctl), 32'(RUN_DEF));
    tick();

    // Timeout: wait counter runs 1..4, then ERROR
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("timeout_freeze_run", 32'(ctl), 32'(FREEZE_RUN));
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("timeout_wait_%0d", i), 32'(ctl), 32'(FREEZE_WAIT));
      tick();
    end
    chk("error_state", 32'(hz.ctrl_state), 32'd2);
    chk("error_mem_err", 32'(hz.mem_err), 32'd1);
    chk("error_pc_write", 32'(hz.pc_write), 32'd0);
    chk("error_if_id_write", 32'(hz.IF_ID_write), 32'd0);
    chk("error_mem_req", 32'(hz.mem_req), 32'd0);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("error_sticky_state", 32'(hz.ctrl_state), 32'd2);
    chk("error_sticky_mem_req", 32'(hz.mem_req), 32'd0);
    reset = 1'b1;
    #1;
    chk("error_reset_outputs", 32'(ctl), 32'(ALL_ZERO));
    tick();
    reset = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("error_cleared", 32'(ctl), 32'(RUN_DEF));
    tick();

    // Reset asserted in the middle of a memory wait
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("midwait_state", 32'(hz.ctrl_state), 32'd1);
    reset = 1'b1;
    #1;
    chk("midwait_reset_outputs", 32'(ctl), 32'(ALL_ZERO));
    tick();
    reset = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midwait_after_reset", 32'(ctl), 32'(RUN_DEF));
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_reset", stall_cycles, 32'd0);
    chk("perf_flush_reset", flush_count, 32'd0);
    chk("perf_memwait_reset", mem_wait_cycles, 32'd0);
    tick();
    drive(5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("perf_stall_one", stall_cycles, 32'd1);
    chk("perf_flush_one", flush_count, 32'd1);
    chk("perf_memwait_zero", mem_wait_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
